envelope_sequencer: RTL and testbench

//  Run controller for the sine_cos -> envelope measurement path.
//  - On start: flushes the envelope peak registers, enables the generator and waits a settle time.
//  - Then observes NUM_PERIODS full periods, timed by envelope posen pulses.
//  - Then captures maxout/minout and reports amplitude, midpoint and period with a done pulse.
//  - Sits between the host/control logic and the envelope/sine_cos instances.

---
 rtl/envelope_sequencer_if.sv | 35 +++
 rtl/envelope_sequencer.sv | 150 +++++++++++++++
 tb/tb_envelope_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/envelope_sequencer_if.sv
// Host and envelope-side signals of the envelope run controller.
// slave = sequencer, master = host/envelope model driving it.
interface envelope_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             posen;
  logic             negen;
  logic [WIDTH-1:0] maxout;
  logic [WIDTH-1:0] minout;
  logic             gen_en;
  logic             env_reset;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [WIDTH:0]   amplitude;
  logic [WIDTH-1:0] midpoint;
  logic [CNT_W-1:0] period;

  modport slave (
    input  start, abort, posen, negen,
    input  maxout, minout,
    output gen_en, env_reset, busy, done,
    output timeout, amplitude, midpoint, period
  );

  modport master (
    output start, abort, posen, negen,
    output maxout, minout,
    input  gen_en, env_reset, busy, done,
    input  timeout, amplitude, midpoint, period
  );
endinterface

// File: rtl/envelope_sequencer.sv
// Run controller for the sine_cos -> envelope path:
// flush, settle, time NUM_PERIODS periods, capture.
module envelope_sequencer #(
  parameter int WIDTH         = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int NUM_PERIODS   = 4,
  parameter int TIMEOUT       = 60000
) (
  input logic                  clk,
  input logic                  reset,
  envelope_sequencer_if.slave  bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int PW = $clog2(NUM_PERIODS + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SETTLE,
    S_MEASURE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state;
  logic [SW-1:0]    step;
  logic [PW-1:0]    pcnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] cand;
  logic [CNT_W-1:0] meas_cnt;
  logic [CNT_W-1:0] idle_cnt;

  logic signed [WIDTH:0] mx;
  logic signed [WIDTH:0] mn;
  logic signed [WIDTH:0] sum;
  logic [WIDTH:0]        amp;
  logic [CNT_W-1:0]      per_nxt;
  logic                  strobe;
  logic                  last;
  logic                  tmo;

  // Sign-extended arithmetic and per-cycle MEASURE decisions.
  always_comb begin
    mx      = $signed({bus.maxout[WIDTH-1], bus.maxout});
    mn      = $signed({bus.minout[WIDTH-1], bus.minout});
    sum     = mx + mn;
    amp     = mx - mn;
    per_nxt = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
    strobe  = bus.posen | bus.negen;
    last    = bus.posen && (pcnt == PW'(NUM_PERIODS));
    tmo     = (meas_cnt == CNT_W'(TIMEOUT - 1)) ||
              ((idle_cnt == CNT_W'(TIMEOUT - 1)) && !strobe);
  end

  // Sequencer FSM with registered outputs; abort overrides any run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      step          <= '0;
      pcnt          <= '0;
      per_cnt       <= '0;
      cand          <= '0;
      meas_cnt      <= '0;
      idle_cnt      <= '0;
      bus.gen_en    <= 1'b0;
      bus.env_reset <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.amplitude <= '0;
      bus.midpoint  <= '0;
      bus.period    <= '0;
    end else if (bus.abort && state != S_IDLE) begin
      state         <= S_IDLE;
      bus.gen_en    <= 1'b0;
      bus.env_reset <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start && !bus.abort) begin
            state         <= S_FLUSH;
            step          <= '0;
            bus.timeout   <= 1'b0;
            bus.busy      <= 1'b1;
            bus.env_reset <= 1'b0;
            bus.gen_en    <= 1'b0;
          end
        end
        S_FLUSH: begin
          step <= step + 1'b1;
          if (step == SW'(1)) begin
            state         <= S_SETTLE;
            step          <= '0;
            bus.env_reset <= 1'b1;
            bus.gen_en    <= 1'b1;
          end
        end
        S_SETTLE: begin
          step <= step + 1'b1;
          if (step == SW'(SETTLE_CYCLES - 1)) begin
            state    <= S_MEASURE;
            pcnt     <= '0;
            per_cnt  <= '0;
            meas_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        S_MEASURE: begin
          meas_cnt <= meas_cnt + 1'b1;
          idle_cnt <= strobe ? '0 : idle_cnt + 1'b1;
          if (bus.posen) begin
            pcnt    <= pcnt + 1'b1;
            per_cnt <= '0;
            if (pcnt != '0) cand <= per_nxt;
          end else begin
            per_cnt <= per_nxt;
          end
          if (last) begin
            state <= S_CAPTURE;
          end else if (tmo) begin
            state       <= S_DONE;
            bus.timeout <= 1'b1;
            bus.done    <= 1'b1;
            bus.gen_en  <= 1'b0;
          end
        end
        S_CAPTURE: begin
          state         <= S_DONE;
          bus.amplitude <= amp;
          bus.midpoint  <= WIDTH'(sum >>> 1);
          bus.period    <= cand;
          bus.done      <= 1'b1;
          bus.gen_en    <= 1'b0;
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_envelope_sequencer.sv
// Scoreboard bench for envelope_sequencer: runs are
// predicted from posen schedules, done pulses checked.
module tb_envelope_sequencer;
  localparam int W  = 16;
  localparam int CW = 16;
  localparam int S  = 4;
  localparam int NP = 2;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  envelope_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus();

  envelope_sequencer #(
    .WIDTH(W), .CNT_W(CW), .SETTLE_CYCLES(S),
    .NUM_PERIODS(NP), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    int edge_;
    int tmo;
    int amp;
    int mid;
    int per;
  } req_t;

  req_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int m_amp = 0;
  int m_mid = 0;
  int m_per = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest prediction.
  always @(negedge clk) begin
    req_t e;
    if (rst_n && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e = q.pop_front();
        check("done_cycle", cyc, e.edge_);
        check("timeout", 32'(bus.timeout), e.tmo);
        check("amplitude", 32'(bus.amplitude), e.amp);
        check("midpoint", 32'(bus.midpoint), e.mid);
        check("period", 32'(bus.period), e.per);
      end
    end
  end

  task automatic reset_values(string t);
    check({t, "_gen_en"}, 32'(bus.gen_en), 0);
    check({t, "_env_reset"}, 32'(bus.env_reset), 1);
    check({t, "_busy"}, 32'(bus.busy), 0);
    check({t, "_done"}, 32'(bus.done), 0);
    check({t, "_timeout"}, 32'(bus.timeout), 0);
    check({t, "_amplitude"}, 32'(bus.amplitude), m_amp);
    check({t, "_midpoint"}, 32'(bus.midpoint), m_mid);
    check({t, "_period"}, 32'(bus.period), m_per);
  endtask

  // One run: posen at relative edges first, first+gap, ...
  // Edge k0 samples start; MEASURE samples edges k0+3+S on.
  task automatic run(int mx, int mn, int first, int gmin,
                     int gmax, bit nopos, bit hold);
    bit pz[512];
    int t, k0, cnt, prev, de, per, tmo, r;
    req_t e;
    for (int i = 0; i < 512; i++) pz[i] = 1'b0;
    if (!nopos) begin
      t = first;
      while (t < 512) begin
        pz[t] = 1'b1;
        t += int'($urandom_range(gmax, gmin));
      end
    end
    cnt = 0; prev = 0; per = m_per; de = 0; tmo = 0;
    for (int j = 1; j <= TO; j++) begin
      r = 2 + S + j;
      if (pz[r]) begin
        cnt++;
        if (cnt > 1) per = r - prev;
        prev = r;
        if (cnt == NP + 1) begin
          de = r + 1;
          break;
        end
      end
      if (j == TO) begin
        de = r;
        tmo = 1;
      end
    end
    if (per > 65535) per = 65535;
    @(negedge clk);
    k0 = cyc + 1;
    if (tmo == 0) begin
      m_amp = (mx - mn) & 'h1FFFF;
      m_mid = ((mx + mn) >>> 1) & 'hFFFF;
      m_per = per;
    end
    e.edge_ = k0 + de; e.tmo = tmo;
    e.amp = m_amp; e.mid = m_mid; e.per = m_per;
    q.push_back(e);
    bus.maxout = mx[15:0];
    bus.minout = mn[15:0];
    for (r = 0; r <= de + 1; r++) begin
      bus.start = (r == 0) || (hold && r < 10);
      bus.posen = pz[r];
      bus.negen = 1'($urandom_range(1, 0));
      if (r == 1) begin
        check("start_clears_timeout", 32'(bus.timeout), 0);
        check("run_busy", 32'(bus.busy), 1);
      end
      if (r == 1 || r == 2) begin
        check("flush_env_reset", 32'(bus.env_reset), 0);
        check("flush_gen_en", 32'(bus.gen_en), 0);
      end
      if (r == 3) begin
        check("settle_env_reset", 32'(bus.env_reset), 1);
        check("settle_gen_en", 32'(bus.gen_en), 1);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.posen = 1'b0;
    bus.negen = 1'b0;
    check("end_busy", 32'(bus.busy), 0);
    check("end_gen_en", 32'(bus.gen_en), 0);
  endtask

  task automatic abort_test();
    @(negedge clk);
    for (int r = 0; r <= 12; r++) begin
      bus.start = (r == 0);
      bus.posen = (r == 8);
      bus.abort = (r == 11);
      if (r == 12) begin
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_gen_en", 32'(bus.gen_en), 0);
        check("abort_env_reset", 32'(bus.env_reset), 1);
      end
      @(negedge clk);
    end
    bus.abort = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_amplitude", 32'(bus.amplitude), m_amp);
    check("abort_period", 32'(bus.period), m_per);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    check("start_abort_busy_later", 32'(bus.busy), 0);
  endtask

  task automatic reset_test();
    @(negedge clk);
    bus.maxout = 16'd77;
    bus.minout = 16'd11;
    for (int r = 0; r < 5; r++) begin
      bus.start = (r == 0);
      @(negedge clk);
    end
    check("pre_reset_gen_en", 32'(bus.gen_en), 1);
    rst_n = 1'b0;
    #1;
    m_amp = 0; m_mid = 0; m_per = 0;
    reset_values("midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int mx, mn, gmin;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.posen = 1'b0; bus.negen = 1'b0;
    bus.maxout = '0;  bus.minout = '0;
    repeat (3) @(negedge clk);
    reset_values("in_rst");
    rst_n = 1'b1;
    @(negedge clk);
    reset_values("post_rst");
    run(1000, -1000, 8, 20, 20, 0, 0);
    run(300, -100, 3, 12, 12, 0, 0);
    run(32767, -32768, 7, 9, 9, 0, 0);
    run(5, 5, 1, 1, 1, 1, 0);
    run(500, 200, 7, 1, 1, 0, 0);
    abort_test();
    run(-20, -300, 5, 6, 15, 0, 1);
    reset_test();
    run(1234, -4321, 9, 17, 17, 0, 0);
    repeat (8) begin
      mx = int'($urandom_range(65535, 0)) - 32768;
      mn = int'($urandom_range(65535, 0)) - 32768;
      gmin = int'($urandom_range(10, 1));
      run(mx, mn, int'($urandom_range(15, 1)), gmin,
          gmin + int'($urandom_range(20, 0)), 0, 0);
    end
    repeat (5) @(negedge clk);
    check("pending_dones", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
